// File: rtl/ripple_count_ctrl_pkg.sv
// Shared types and constants for the ripple counter sequencer.
// next_expected() gives the counter value after a burst of down-counts.
package ripple_count_ctrl_pkg;

    localparam int WIDTH_DEF      = 4;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PULSE_HI,
        PULSE_LO,
        SETTLE,
        RESP
    } state_t;

    // The caller keeps the low WIDTH bits, which is the mod 2^WIDTH wrap.
    function automatic logic [31:0] next_expected(input logic [31:0] cur,
                                                  input logic [31:0] n);
        return cur - n;
    endfunction

endpackage

// File: rtl/rcc_pulse_gen.sv
// Remaining-pulse counter and the cnt_clk flop for the ripple counter.
// done means no pulses remain once the current cycle's decrement lands.
module rcc_pulse_gen
    import ripple_count_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic             pulse,
    input  logic             step,
    output logic             done,
    output logic             cnt_clk
);

    logic [WIDTH-1:0] rem;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem     <= '0;
            cnt_clk <= 1'b0;
        end else begin
            cnt_clk <= pulse;
            if (start)
                rem <= n;
            else if (step)
                rem <= rem - WIDTH'(1);
        end
    end

    assign done = step ? (rem == WIDTH'(1)) : (rem == '0);

endmodule

// File: rtl/ripple_count_ctrl.sv
// Burst sequencer driving a 4-bit asynchronous down-counter, then sampling it.
// Optional checker enabled by defining RIPPLE_COUNT_CTRL_CHECK_EN.
module ripple_count_ctrl
    import ripple_count_ctrl_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_n,
    input  logic             cmd_clear,
    output logic             cnt_clk,
    output logic             cnt_rst_n,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_count,
    output logic             rsp_err,
    output logic             busy
);

    localparam int SCW = $clog2(SETTLE_CYC) + 1;

    state_t           state;
    state_t           state_nx;
    logic [SCW-1:0]   settle_cnt;
    logic             accept;
    logic             pulse_done;
    logic             settle_done;
    logic             cmd_ready_q;
    logic             cnt_rst_n_q;
    logic [WIDTH-1:0] rsp_count_q;

    assign accept      = cmd_valid && cmd_ready_q;
    assign settle_done = (settle_cnt == '0);

    rcc_pulse_gen #(
        .WIDTH (WIDTH)
    ) u_pulse_gen (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .n       (cmd_n),
        .pulse   (state_nx == PULSE_HI),
        .step    (state == PULSE_LO),
        .done    (pulse_done),
        .cnt_clk (cnt_clk)
    );

    // NOTE: state_nx is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_clear)
                        state_nx = CLEAR;
                    else if (cmd_n != '0)
                        state_nx = PULSE_HI;
                    else
                        state_nx = SETTLE;
                end
            end
            CLEAR:    state_nx = pulse_done ? SETTLE : PULSE_HI;
            PULSE_HI: state_nx = PULSE_LO;
            PULSE_LO: state_nx = pulse_done ? SETTLE : PULSE_HI;
            SETTLE:   if (settle_done) state_nx = RESP;
            RESP:     if (rsp_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Counter-facing strobes are decoded from state_nx so they leave flops, not gates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            cnt_rst_n_q <= 1'b0;
            settle_cnt  <= '0;
            rsp_count_q <= '0;
        end else begin
            state       <= state_nx;
            cmd_ready_q <= (state_nx == IDLE);
            cnt_rst_n_q <= (state_nx != CLEAR);
            if (state != SETTLE)
                settle_cnt <= SCW'(SETTLE_CYC - 1);
            else if (!settle_done)
                settle_cnt <= settle_cnt - SCW'(1);
            if (state == SETTLE && settle_done)
                rsp_count_q <= cnt_q;
        end
    end

`ifdef RIPPLE_COUNT_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             err_q;

    // exp follows the ideal counter and resyncs to each returned sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept)
                exp_q <= WIDTH'(next_expected(cmd_clear ? 32'd0 : 32'(exp_q), 32'(cmd_n)));
            else if (state == RESP && rsp_ready)
                exp_q <= rsp_count_q;
            if (state == SETTLE && settle_done)
                err_q <= (cnt_q != exp_q);
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign cnt_rst_n = cnt_rst_n_q;
    assign rsp_valid = (state == RESP);
    assign rsp_count = rsp_count_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Self-checking bench for ripple_count_ctrl with an attached down-counter model.
// Expected values come from arithmetic on the command stream, not from the DUT.
module tb_ripple_count_ctrl;

    localparam int W = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_n;
    logic         cmd_clear;
    logic         cnt_clk;
    logic         cnt_rst_n;
    logic [W-1:0] cnt_q;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_count;
    logic         rsp_err;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int phys  = 0;
    int chk   = 0;

    ripple_count_ctrl #(
        .WIDTH      (W),
        .SETTLE_CYC (S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_n     (cmd_n),
        .cmd_clear (cmd_clear),
        .cnt_clk   (cnt_clk),
        .cnt_rst_n (cnt_rst_n),
        .cnt_q     (cnt_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_count (rsp_count),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Attached ripple counter: decrements on cnt_clk rising, can drop one chosen edge.
    logic [W-1:0] ctr;
    int edge_no = 0;
    int skip_at = -1;
    int clr_no  = 0;
    int hi_run  = 0;
    int hi_viol = 0;

    always @(posedge cnt_clk) edge_no <= edge_no + 1;

    always @(posedge cnt_clk or negedge cnt_rst_n) begin
        if (!cnt_rst_n)
            ctr <= '0;
        else if (edge_no != skip_at)
            ctr <= ctr - 1'b1;
    end

    assign cnt_q = ctr;

    always @(negedge cnt_rst_n) clr_no <= clr_no + 1;

    always @(negedge clk) begin
        if (cnt_clk) begin
            if (hi_run >= 1) hi_viol <= hi_viol + 1;
            hi_run <= hi_run + 1;
        end else begin
            hi_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("cmd_ready_wait", 32'(ok), 1);
    endtask

    task automatic run_cmd(input int n, input bit clear, input int hold, input bit early, input int skip);
        int lat, p0, c0, want_lat, want_cnt, want_err;
        bit ok;
        want_lat = 1 + int'(clear) + 2 * n + S;
        phys = ((clear ? 0 : phys) - n + ((skip >= 0 && skip < n) ? 1 : 0)) & 15;
        chk  = ((clear ? 0 : chk) - n) & 15;
        want_cnt = phys;
`ifdef RIPPLE_COUNT_CTRL_CHECK_EN
        want_err = (phys != chk) ? 1 : 0;
`else
        want_err = 0;
`endif
        wait_ready(ok);
        if (!ok) return;
        p0 = edge_no;
        c0 = clr_no;
        skip_at = (skip >= 0) ? edge_no + skip : -1;
        rsp_ready = early;
        cmd_n = W'(n);
        cmd_clear = clear;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("rsp_valid_wait", 32'(ok), 1);
        if (!ok) return;
        check("latency", lat, want_lat);
        check("rsp_count", 32'(rsp_count), want_cnt);
        check("rsp_err", 32'(rsp_err), want_err);
        check("pulses", edge_no - p0, n);
        check("clear_pulses", clr_no - c0, int'(clear));
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(rsp_valid), 1);
                check("hold_count", 32'(rsp_count), want_cnt);
                check("hold_err", 32'(rsp_err), want_err);
                check("hold_cmd_ready", 32'(cmd_ready), 0);
                check("hold_busy", 32'(busy), 1);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("post_valid", 32'(rsp_valid), 0);
        check("post_cmd_ready", 32'(cmd_ready), 1);
        chk = want_cnt;
        skip_at = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int p0;
        cmd_valid = 1'b0;
        cmd_n     = '0;
        cmd_clear = 1'b0;
        rsp_ready = 1'b0;

        #2 rst = 1'b0;
        #1;
        check("rst_cnt_rst_n", 32'(cnt_rst_n), 0);
        check("rst_cnt_clk", 32'(cnt_clk), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_count", 32'(rsp_count), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_cmd_ready_low", 32'(cmd_ready), 0);
        @(posedge clk);
        #1;
        check("rel_cmd_ready_high", 32'(cmd_ready), 1);
        check("rel_cnt_rst_n_high", 32'(cnt_rst_n), 1);

        // Directed: clear+3, follow-up 5 with long hold, idle read, skipped edge, resync.
        run_cmd(3, 1'b1, 0, 1'b0, -1);
        run_cmd(5, 1'b0, 10, 1'b0, -1);
        run_cmd(0, 1'b0, 0, 1'b0, -1);
        run_cmd(4, 1'b1, 0, 1'b0, 1);
        run_cmd(1, 1'b0, 0, 1'b0, -1);
        run_cmd(0, 1'b1, 0, 1'b1, -1);
        run_cmd(2, 1'b0, 0, 1'b1, -1);

        // Reset during the second pulse of a 6-pulse burst.
        wait_ready(ok);
        if (ok) begin
            p0 = edge_no;
            cmd_n = W'(6);
            cmd_clear = 1'b0;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (edge_no - p0 >= 2) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("second_pulse_wait", 32'(ok), 1);
            rst = 1'b0;
            #1;
            check("mid_rst_cnt_clk", 32'(cnt_clk), 0);
            check("mid_rst_cnt_rst_n", 32'(cnt_rst_n), 0);
            check("mid_rst_busy", 32'(busy), 0);
            check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
            check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
            phys = 0;
            chk  = 0;
            #2 rst = 1'b1;
            run_cmd(1, 1'b0, 0, 1'b0, -1);
        end

        // Randomized commands, occasional dropped counter edge and response back-pressure.
        for (int t = 0; t < 24; t++) begin
            int n, hold, skip;
            bit clear, early;
            n     = int'($urandom_range(0, 15));
            clear = 1'($urandom_range(0, 1));
            hold  = int'($urandom_range(0, 3));
            early = ($urandom_range(0, 3) == 0);
            skip  = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_cmd(n, clear, hold, early, skip);
        end

        check("cnt_clk_high_width", hi_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
